// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous memory.
// Every access runs IDLE -> ACCESS -> RESP; arbitration only happens in IDLE.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_done,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_done,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_out,
    output logic                  busy
);
    localparam int NUM_PORTS = 2;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                               state, state_nxt;
    logic   [NUM_PORTS-1:0]               req_vec, gnt_vec, done_vec;
    req_t   [NUM_PORTS-1:0]               req_in;
    logic   [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata_vec;
    req_t                                 lat;
    logic                                 owner, last, win, any_req;

    assign req_vec   = {m1_req, m0_req};
    assign req_in[0] = {m0_we, m0_addr, m0_wdata};
    assign req_in[1] = {m1_we, m1_addr, m1_wdata};
    assign any_req   = |req_vec;

    // On a tie the port that was not served last wins.
    always_comb begin
        win = ~last;
        if (req_vec == 2'b01)      win = 1'b0;
        else if (req_vec == 2'b10) win = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner <= 1'b0;
            last  <= 1'b1;
            lat   <= '0;
        end else if (state == IDLE && any_req) begin
            owner <= win;
            last  <= win;
            lat   <= req_in[win];
        end
    end

    // Memory side is driven only from latched state, never from mem_out.
    assign mem_we   = (state == ACCESS) & lat.we;
    assign mem_addr = lat.addr;
    assign mem_data = lat.wdata;
    assign busy     = (state != IDLE);

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        logic sel;
        assign sel          = (owner == 1'(i));
        assign gnt_vec[i]   = rst_n & (state == IDLE) & req_vec[i] & (win == 1'(i));
        assign done_vec[i]  = (state == RESP) & sel;
        assign rdata_vec[i] = done_vec[i] ? mem_out : '0;
    end

    assign m0_gnt   = gnt_vec[0];
    assign m1_gnt   = gnt_vec[1];
    assign m0_done  = done_vec[0];
    assign m1_done  = done_vec[1];
    assign m0_rdata = rdata_vec[0];
    assign m1_rdata = rdata_vec[1];
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port synchronous `memory` between the `cpu` (port 0) and a debug/loader requester (port 1), such as a switch-driven memory monitor. It sits between the requesters and the memory instance, on the same slowed clock. Each requester gets a request/grant/done handshake. Contention is resolved round-robin, and every access is sequenced through a fixed three-state machine.

## Interface
- ADDR_WIDTH, 6, memory address width
- DATA_WIDTH, 16, memory data width

- clk  in  1  system clock (slowed clock domain of the memory)
- rst_n  in  1  asynchronous active-low reset
- m0_req  in  1  port 0 request; held high until m0_gnt
- m0_we  in  1  port 0 write (1) / read (0)
- m0_addr  in  ADDR_WIDTH  port 0 address
- m0_wdata  in  DATA_WIDTH  port 0 write data
- m0_gnt  out  1  port 0 request accepted (one-cycle pulse)
- m0_done  out  1  port 0 access complete (one-cycle pulse)
- m0_rdata  out  DATA_WIDTH  port 0 read data, valid while m0_done=1
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_done, m1_rdata: same as port 0, for port 1
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_data  out  DATA_WIDTH  memory write data
- mem_out  in  DATA_WIDTH  memory read data; registered, valid the cycle after the address edge
- busy  out  1  arbiter not in IDLE

## Operation
- Reset is asynchronous and active-low: clk and rst_n; polarity and synchronicity fixed.
- State machine has three states:
  - IDLE: if any req, go to ACCESS; otherwise stay.
  - ACCESS: go to RESP unconditionally.
  - RESP: go to IDLE unconditionally.
- Arbitration happens only in IDLE:
  - Only one req high: that port wins.
  - Both high: the port not served last wins.
  - `last` register resets to 1, so port 0 wins the first tie.
- In IDLE, winner's gnt is driven high combinationally (gnt = IDLE & winner).
- On the IDLE→ACCESS edge, latch owner, we, addr and wdata into internal registers, and update `last` to owner.
- ACCESS:
  - mem_addr and mem_data come from the latched registers.
  - mem_we = latched we.
  - The memory samples at the end of ACCESS.
- RESP:
  - Owner's done = 1.
  - Owner's rdata = mem_out, passed through combinationally. It is meaningful for reads only; on writes it shows the memory output for that address.
  - mem_we = 0.
- Outside ACCESS: mem_we = 0; mem_addr and mem_data hold the last latched values.
- Non-owner done is always 0. Non-owner rdata is unspecified but must not be X after reset.
- Requester rules:
  - Drop req, or present the next request, after seeing gnt.
  - A req still high in RESP is not granted until the next IDLE.
  - A req deasserted before gnt is silently abandoned; no grant is owed.

## Timing
- Reset values: state IDLE, last=1, owner=0, latched we/addr/wdata=0, mem_we=0, mem_addr=0, mem_data=0, gnt=0, done=0, busy=0.
- Per access, with req sampled high in IDLE cycle n:
  - gnt in cycle n.
  - mem_we/mem_addr valid in cycle n+1 (ACCESS).
  - done and rdata valid in cycle n+2 (RESP).
  - Back to IDLE in cycle n+3.
- Latency is 2 cycles from gnt to done; peak throughput is one access per 3 cycles.
- Both ports requesting continuously are served strictly alternately: 0,1,0,1… Worst-case wait is 3 cycles.
- Reset asserted mid-access (ACCESS or RESP) immediately drives the state to IDLE and mem_we, gnt and done to 0. The interrupted write may or may not have been committed; no done is issued for it.
- busy = 1 in ACCESS and RESP.
- No combinational path from mem_out to any mem_* output. gnt depends combinationally on req only through IDLE arbitration.

## Test plan
- Reset defaults: hold rst_n=0 with random inputs → all outputs at reset values; mem_we=0 throughout.
- Single write then read on port 0:
  - Write addr=5, data=16'hBEEF → m0_gnt at cycle n; mem_we=1, mem_addr=5, mem_data=BEEF in n+1; m0_done in n+2.
  - Then read addr=5 → m0_rdata=BEEF with m0_done; m1_done stays 0.
- Simultaneous first requests: both req at the first IDLE after reset, port 0 reads addr 1, port 1 reads addr 2 → port 0 granted first, port 1 granted at the next IDLE 3 cycles later, each done carrying its own address's data.
- Continuous contention: both req held high for 12 cycles → grants alternate 0,1,0,1 with gnt pulses exactly 3 cycles apart; no port granted twice in a row.
- Late/abandoned request: m1_req pulsed only during ACCESS of a port 0 access → no m1_gnt ever.
- Reset mid-operation: assert rst_n=0 during ACCESS of a write to addr 7 → mem_we falls immediately, no done, state IDLE. After release, a fresh port 0 request completes normally in 3 cycles.
